axi_stream_insert_header: RTL and testbench

- Prepends a variable-length header (1..DATA_BYTE_WD bytes) to an AXI-Stream packet.
- Re-packs header plus payload into a contiguous, MSB-first byte stream.
- Sits between a payload source and a downstream AXI-Stream sink.
- Exactly one header is consumed per packet.

---
 rtl/axi_stream_insert_header_pkg.sv | 35 +++
 rtl/axi_stream_insert_header_if.sv | 49 ++++
 rtl/axis_hdr_byte_merge.sv | 27 ++
 rtl/axi_stream_insert_header.sv | 144 ++++++++++++++
 tb/tb_axi_stream_insert_header.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_stream_insert_header_pkg.sv
// Shared constants and byte-count helpers
// for the AXI-Stream header inserter.
package axi_stream_insert_header_pkg;

  localparam int DATA_WD_DEF = 32;
  localparam int MAX_BYTES = 64;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FLUSH
  } ins_state_e;

  function automatic int unsigned popcount(
    input logic [MAX_BYTES-1:0] keep
  );
    int unsigned n = 0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (keep[i]) n++;
    return n;
  endfunction

  // MSB-aligned run of cnt ones inside a width-bit keep bus.
  function automatic logic [MAX_BYTES-1:0] msb_mask(
    input int unsigned cnt,
    input int unsigned width
  );
    logic [MAX_BYTES-1:0] m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++)
      if (i < width && i + cnt >= width)
        m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/axi_stream_insert_header_if.sv
// Payload, header and output stream
// signals of the header inserter.
interface axi_stream_insert_header_if
  import axi_stream_insert_header_pkg::*;
#(
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD)
);

  logic                    valid_in;
  logic [DATA_WD-1:0]      data_in;
  logic [DATA_BYTE_WD-1:0] keep_in;
  logic                    last_in;
  logic                    ready_in;

  logic                    valid_out;
  logic [DATA_WD-1:0]      data_out;
  logic [DATA_BYTE_WD-1:0] keep_out;
  logic                    last_out;
  logic                    ready_out;

  logic                    valid_insert;
  logic [DATA_WD-1:0]      data_insert;
  logic [DATA_BYTE_WD-1:0] keep_insert;
  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
  logic                    ready_insert;

  modport master (
    output valid_in, data_in, keep_in, last_in,
    input  ready_in,
    input  valid_out, data_out, keep_out, last_out,
    output ready_out,
    output valid_insert, data_insert, keep_insert,
    output byte_insert_cnt,
    input  ready_insert
  );

  modport slave (
    input  valid_in, data_in, keep_in, last_in,
    output ready_in,
    output valid_out, data_out, keep_out, last_out,
    input  ready_out,
    input  valid_insert, data_insert, keep_insert,
    input  byte_insert_cnt,
    output ready_insert
  );

endinterface

// File: rtl/axis_hdr_byte_merge.sv
// Joins h carried bytes with the top of the
// incoming word; low h bytes become the carry.
module axis_hdr_byte_merge
  import axi_stream_insert_header_pkg::*;
#(
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int CNT_W = 3
) (
  input  logic [DATA_WD-1:0] carry,
  input  logic [DATA_WD-1:0] data,
  input  logic [CNT_W-1:0]   h,
  output logic [DATA_WD-1:0] word,
  output logic [DATA_WD-1:0] next_carry
);

  logic [DATA_WD-1:0] low_mask;

  // Carry bytes sit LSB-aligned, so they land
  // directly above data once h bytes drop off.
  assign word = DATA_WD'({carry, data} >> {h, 3'b000});

  assign low_mask =
    ~({DATA_WD{1'b1}} << {h, 3'b000});

  assign next_carry = data & low_mask;

endmodule

// File: rtl/axi_stream_insert_header.sv
// Prepends a 1..N byte header to a stream and
// re-packs header plus payload MSB-first.
module axi_stream_insert_header
  import axi_stream_insert_header_pkg::*;
#(
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD)
) (
  input logic clk,
  input logic rst,
  axi_stream_insert_header_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_BYTE_WD + 1);

  ins_state_e              state;
  logic [DATA_WD-1:0]      carry;
  logic [CNT_W-1:0]        h;
  logic [CNT_W-1:0]        flush_cnt;
  logic                    valid_q;
  logic [DATA_WD-1:0]      data_q;
  logic [DATA_BYTE_WD-1:0] keep_q;
  logic                    last_q;
  logic                    ready_insert_q;

  logic [DATA_WD-1:0]      in_mask;
  logic [DATA_WD-1:0]      hdr_mask;
  logic [DATA_WD-1:0]      merge_data;
  logic [DATA_WD-1:0]      merge_word;
  logic [DATA_WD-1:0]      merge_carry;
  logic [DATA_BYTE_WD-1:0] keep_last;
  logic [DATA_BYTE_WD-1:0] keep_flush;
  logic [CNT_W-1:0]        h_new;
  int unsigned             hl;
  logic                    ready_in_c;
  logic                    in_fire;
  logic                    out_free;
  logic [BYTE_CNT_WD-1:0]  unused_cnt;

  assign unused_cnt = bus.byte_insert_cnt;

  for (genvar i = 0; i < DATA_BYTE_WD; i++) begin : g_lane
    assign in_mask[i*8 +: 8] = {8{bus.keep_in[i]}};
    assign hdr_mask[i*8 +: 8] = {8{bus.keep_insert[i]}};
  end

  assign h_new =
    CNT_W'(popcount(MAX_BYTES'(bus.keep_insert)));
  assign hl =
    32'(h) + popcount(MAX_BYTES'(bus.keep_in));
  assign keep_last =
    DATA_BYTE_WD'(msb_mask(hl, DATA_BYTE_WD));
  assign keep_flush =
    DATA_BYTE_WD'(msb_mask(32'(flush_cnt), DATA_BYTE_WD));

  // Once a last beat is queued, the next packet's
  // payload must wait for a fresh header.
  assign out_free = !valid_q || bus.ready_out;
  assign ready_in_c = (state == DATA) &&
    (!valid_q || (bus.ready_out && !last_q));
  assign in_fire = bus.valid_in && ready_in_c;

  assign merge_data = (state == FLUSH) ? '0 :
    (bus.data_in & in_mask);

  axis_hdr_byte_merge #(
    .DATA_WD (DATA_WD),
    .CNT_W   (CNT_W)
  ) u_merge (
    .carry      (carry),
    .data       (merge_data),
    .h          (h),
    .word       (merge_word),
    .next_carry (merge_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      carry <= '0;
      h <= '0;
      flush_cnt <= '0;
      valid_q <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
      ready_insert_q <= 1'b0;
    end else begin
      if (valid_q && bus.ready_out)
        valid_q <= 1'b0;
      unique case (state)
        IDLE: begin
          ready_insert_q <= 1'b1;
          if (bus.valid_insert && ready_insert_q) begin
            carry <= bus.data_insert & hdr_mask;
            h <= h_new;
            ready_insert_q <= 1'b0;
            state <= DATA;
          end
        end
        DATA: begin
          if (in_fire) begin
            valid_q <= 1'b1;
            data_q <= merge_word;
            carry <= merge_carry;
            keep_q <= '1;
            last_q <= 1'b0;
            if (bus.last_in) begin
              if (hl <= DATA_BYTE_WD) begin
                keep_q <= keep_last;
                last_q <= 1'b1;
              end else begin
                flush_cnt <= CNT_W'(hl - DATA_BYTE_WD);
                state <= FLUSH;
              end
            end
          end else if (valid_q && bus.ready_out && last_q) begin
            state <= IDLE;
            ready_insert_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (out_free) begin
            valid_q <= 1'b1;
            data_q <= merge_word;
            keep_q <= keep_flush;
            last_q <= 1'b1;
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready_in = ready_in_c;
  assign bus.valid_out = valid_q;
  assign bus.data_out = data_q;
  assign bus.keep_out = keep_q;
  assign bus.last_out = last_q;
  assign bus.ready_insert = ready_insert_q;

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Scoreboard bench: byte-list reference model,
// decoupled driver and monitor processes.
module tb_axi_stream_insert_header;

  localparam int DW = 32;
  localparam int DB = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_stream_insert_header_if #(.DATA_WD(DW)) bus ();

  axi_stream_insert_header #(.DATA_WD(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t sb[$];
  int total = 0;
  int passed = 0;
  int out_beats = 0;
  bit rand_bp = 0;
  bit gaps = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // Header bytes then payload bytes as one flat list,
  // cut into beats of DB bytes.
  function automatic void expect_pkt(
    input logic [DW-1:0] hdr,
    input logic [DB-1:0] hkeep,
    input logic [DW-1:0] pay[$],
    input int last_n
  );
    logic [7:0] bytes[$];
    beat_t b;
    int h = $countones(hkeep);
    for (int i = h - 1; i >= 0; i--)
      bytes.push_back(hdr[i*8 +: 8]);
    foreach (pay[k]) begin
      int n = (k == pay.size() - 1) ? last_n : DB;
      for (int j = 0; j < n; j++)
        bytes.push_back(pay[k][DW-1-8*j -: 8]);
    end
    while (bytes.size() > 0) begin
      b = '0;
      for (int j = 0; j < DB && bytes.size() > 0; j++) begin
        b.data[DW-1-8*j -: 8] = bytes.pop_front();
        b.keep[DB-1-j] = 1'b1;
      end
      b.last = (bytes.size() == 0);
      sb.push_back(b);
    end
  endfunction

  task automatic send_hdr(input logic [DW-1:0] hdr,
                          input logic [DB-1:0] hkeep);
    bit acc = 0;
    bus.valid_insert = 1'b1;
    bus.data_insert = hdr;
    bus.keep_insert = hkeep;
    bus.byte_insert_cnt = 2'($urandom);
    for (int t = 0; t < 2000 && !acc; t++) begin
      @(negedge clk);
      if (rst) break;
      acc = bus.ready_insert;
      @(posedge clk); #1;
    end
    if (!acc && !rst) begin
      total++;
      $display("FAIL hdr_timeout: ready_insert never seen");
    end
    bus.valid_insert = 1'b0;
  endtask

  task automatic send_pay(input logic [DW-1:0] pay[$],
                          input logic [DB-1:0] lkeep);
    foreach (pay[k]) begin
      bit acc = 0;
      bit lst = (k == pay.size() - 1);
      if (gaps) begin
        bus.valid_in = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      bus.valid_in = 1'b1;
      bus.data_in = pay[k];
      bus.keep_in = lst ? lkeep : '1;
      bus.last_in = lst;
      for (int t = 0; t < 2000 && !acc; t++) begin
        @(negedge clk);
        if (rst) break;
        acc = bus.ready_in;
        @(posedge clk); #1;
      end
      if (rst) break;
      if (!acc) begin
        total++;
        $display("FAIL pay_timeout: ready_in never seen");
        break;
      end
    end
    bus.valid_in = 1'b0;
    bus.last_in = 1'b0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] hdr,
                          input logic [DB-1:0] hkeep,
                          input logic [DW-1:0] pay[$],
                          input int last_n,
                          input int pre);
    logic [DB-1:0] lkeep = '0;
    for (int j = 0; j < last_n; j++) lkeep[DB-1-j] = 1'b1;
    expect_pkt(hdr, hkeep, pay, last_n);
    fork
      send_pay(pay, lkeep);
      begin
        for (int c = 0; c < pre; c++) begin
          @(negedge clk);
          chk("early_ready_in", 64'(bus.ready_in), 64'(0));
        end
        if (pre > 0) begin
          @(posedge clk); #1;
        end
        send_hdr(hdr, hkeep);
      end
    join
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || bus.valid_out) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 500) begin
      total++;
      $display("FAIL drain_timeout: %0d beats left", sb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_first_beat(input int base);
    for (int t = 0; t < 200 && out_beats < base + 1; t++)
      @(posedge clk);
    #2;
  endtask

  initial begin : monitor
    beat_t got;
    beat_t held;
    beat_t exp;
    bit stalled = 0;
    forever begin
      @(negedge clk);
      got = {bus.data_out, bus.keep_out, bus.last_out};
      if (rst) begin
        stalled = 0;
        continue;
      end
      if (stalled) begin
        chk("hold_valid", 64'(bus.valid_out), 64'(1));
        chk("hold_beat", 64'(got), 64'(held));
      end
      stalled = 0;
      if (bus.valid_out) begin
        if (!bus.ready_out) begin
          stalled = 1;
          held = got;
          chk("stall_ready_in", 64'(bus.ready_in), 64'(0));
        end else if (sb.size() == 0) begin
          total++;
          $display("FAIL extra_beat: got %0h none expected", got);
        end else begin
          exp = sb.pop_front();
          chk("beat", 64'(got), 64'(exp));
          out_beats++;
        end
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (rand_bp) bus.ready_out = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [DW-1:0] pay[$];
    logic [DW-1:0] hdr;
    int h;
    int nb;
    int base;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.keep_in = '0;
    bus.last_in = 1'b0;
    bus.ready_out = 1'b1;
    bus.valid_insert = 1'b0;
    bus.data_insert = '0;
    bus.keep_insert = '0;
    bus.byte_insert_cnt = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", 64'(bus.valid_out), 64'(0));
    chk("rst_data_out", 64'(bus.data_out), 64'(0));
    chk("rst_keep_out", 64'(bus.keep_out), 64'(0));
    chk("rst_last_out", 64'(bus.last_out), 64'(0));
    chk("rst_ready_in", 64'(bus.ready_in), 64'(0));
    chk("rst_ready_insert", 64'(bus.ready_insert), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("release_ready_insert", 64'(bus.ready_insert), 64'(0));
    @(posedge clk); #1;
    chk("first_ready_insert", 64'(bus.ready_insert), 64'(1));

    pay = {32'h11223344, 32'h55667788};
    send_pkt(32'hAABBCCDD, 4'b0011, pay, 4, 0);
    drain();

    pay = {32'h11223344};
    send_pkt(32'hAABBCCDD, 4'b1111, pay, 4, 0);
    drain();

    pay = {32'h11223344, 32'h55660000};
    send_pkt(32'h000000DD, 4'b0001, pay, 2, 0);
    drain();

    base = out_beats;
    pay = {32'h11223344, 32'h55667788};
    fork
      send_pkt(32'hAABBCCDD, 4'b0011, pay, 4, 0);
    join_none
    wait_first_beat(base);
    bus.ready_out = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.ready_out = 1'b1;
    drain();

    pay = {32'h11223344, 32'h55667788};
    send_pkt(32'hAABBCCDD, 4'b0011, pay, 4, 5);
    drain();

    base = out_beats;
    pay = {32'h11223344, 32'h55667788};
    fork
      send_pkt(32'hAABBCCDD, 4'b0011, pay, 4, 0);
    join_none
    wait_first_beat(base);
    chk("pre_rst_valid_out", 64'(bus.valid_out), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_valid_out", 64'(bus.valid_out), 64'(0));
    chk("mid_rst_data_out", 64'(bus.data_out), 64'(0));
    chk("mid_rst_keep_out", 64'(bus.keep_out), 64'(0));
    chk("mid_rst_last_out", 64'(bus.last_out), 64'(0));
    chk("mid_rst_ready_in", 64'(bus.ready_in), 64'(0));
    chk("mid_rst_ready_insert", 64'(bus.ready_insert), 64'(0));
    sb.delete();
    repeat (3) @(negedge clk);
    sb.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready_insert", 64'(bus.ready_insert), 64'(1));
    pay = {32'h11223344, 32'h55660000};
    send_pkt(32'h000000DD, 4'b0001, pay, 2, 0);
    drain();

    rand_bp = 1;
    gaps = 1;
    for (int p = 0; p < 40; p++) begin
      h = $urandom_range(1, DB);
      hdr = $urandom;
      nb = $urandom_range(1, 5);
      pay = {};
      for (int k = 0; k < nb; k++) pay.push_back($urandom);
      send_pkt(hdr, 4'((1 << h) - 1), pay,
               $urandom_range(1, DB), 0);
    end
    drain();
    rand_bp = 0;
    bus.ready_out = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
